// File: rtl/etm_mul_pipe.sv
// Three-stage pipelined unsigned multiplier with an exact mode and an ETM
// (exact high part, OR-mask low part) approximate mode, plus an approx-result counter.
module etm_mul_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SPLIT = WIDTH / 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_prod,
  output logic               out_approx,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   approx_cnt
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned NW = 2 * SPLIT;

  typedef logic [PW-1:0] prod_t;
  typedef enum logic [1:0] {
    PATH_FULL,
    PATH_LO,
    PATH_APPROX
  } path_e;

  logic en;
  logic transfer;

  // Stage 1 state
  logic             v1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  path_e            path1;
  path_e            path_in;

  // Stage 2 state
  logic             v2;
  logic             approx2;
  prod_t            prod2;
  logic [NW-1:0]    nm2;

  // Stage 2 combinational results
  logic [SPLIT-1:0] lo_or;
  int unsigned      msb;
  logic [NW-1:0]    nm;
  prod_t            prod_sel;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign transfer = out_valid && out_ready;

  always_comb begin
    path_in = PATH_FULL;
    if (in_mode) begin
      if (in_a[WIDTH-1:SPLIT] == '0 && in_b[WIDTH-1:SPLIT] == '0)
        path_in = PATH_LO;
      else
        path_in = PATH_APPROX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      path1 <= PATH_FULL;
    end else if (en) begin
      v1    <= in_valid;
      a1    <= in_a;
      b1    <= in_b;
      path1 <= path_in;
    end
  end

  // NM: all bits up to (msb of the OR'ed low parts) + SPLIT are set
  always_comb begin
    lo_or = a1[SPLIT-1:0] | b1[SPLIT-1:0];
    msb   = 0;
    for (int unsigned i = 0; i < SPLIT; i++) begin
      if (lo_or[i]) msb = i;
    end
    nm = '0;
    for (int unsigned j = 0; j < NW; j++) begin
      nm[j] = (lo_or != '0) && (j <= msb + SPLIT);
    end
  end

  // One multiplier port serves all three paths; the approx path uses the high halves
  always_comb begin
    prod_sel = '0;
    unique case (path1)
      PATH_FULL: prod_sel = prod_t'(a1) * prod_t'(b1);
      PATH_LO:   prod_sel = prod_t'(a1[SPLIT-1:0]) * prod_t'(b1[SPLIT-1:0]);
      default:   prod_sel = prod_t'(a1[WIDTH-1:SPLIT]) * prod_t'(b1[WIDTH-1:SPLIT]);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2      <= 1'b0;
      approx2 <= 1'b0;
      prod2   <= '0;
      nm2     <= '0;
    end else if (en) begin
      v2      <= v1;
      approx2 <= (path1 == PATH_APPROX);
      prod2   <= prod_sel;
      nm2     <= nm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_approx <= 1'b0;
      out_prod   <= '0;
    end else if (en) begin
      out_valid  <= v2;
      out_approx <= approx2;
      out_prod   <= approx2 ? ((prod2 << NW) | prod_t'(nm2)) : prod2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      approx_cnt <= '0;
    end else if (transfer && out_approx && approx_cnt != '1) begin
      approx_cnt <= approx_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_etm_mul_pipe.sv
// Directed-vector and streaming checks for etm_mul_pipe at WIDTH=8, SPLIT=4.
module tb_etm_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic        out_approx;
  logic        cnt_clr;
  logic [15:0] approx_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  etm_mul_pipe #(.WIDTH(8), .SPLIT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_prod(out_prod), .out_approx(out_approx),
    .cnt_clr(cnt_clr), .approx_cnt(approx_cnt)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        mode;
    logic [15:0] prod;
    logic        apx;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: returns {approx, product}
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b, input logic mode);
    logic [15:0] ahi, bhi, alo, blo, nm, p;
    logic [3:0]  l;
    int          top;
    ahi = {12'h0, a[7:4]};
    bhi = {12'h0, b[7:4]};
    alo = {12'h0, a[3:0]};
    blo = {12'h0, b[3:0]};
    if (!mode) begin
      p = {8'h0, a} * {8'h0, b};
      return {1'b0, p};
    end
    if (ahi == 0 && bhi == 0) begin
      p = alo * blo;
      return {1'b0, p};
    end
    l   = a[3:0] | b[3:0];
    nm  = 16'h0;
    top = -1;
    for (int k = 3; k >= 0; k--) begin
      if (l[k] && top < 0) top = k;
    end
    if (top >= 0) nm = (16'h1 << (top + 5)) - 16'h1;
    p = ((ahi * bhi) << 8) | nm;
    return {1'b1, p};
  endfunction

  // Streams n random ops; rdy_mode 0 toggles out_ready each cycle, 1 randomises it
  task automatic stream(input int n, input int rdy_mode, input string tag);
    logic [16:0] q[$];
    logic [16:0] e;
    logic [15:0] held_prod;
    logic        held_apx;
    logic        stalled = 1'b0;
    logic        pend = 1'b0;
    logic        tog = 1'b1;
    int          sent = 0;
    int          got = 0;
    int          budget = n * 6 + 50;
    while (got < n && budget > 0) begin
      budget--;
      if (sent < n && !pend) begin
        in_a    = 8'($urandom);
        in_b    = 8'($urandom);
        in_mode = 1'($urandom);
        pend    = 1'b1;
      end
      in_valid  = pend;
      out_ready = (rdy_mode == 0) ? tog : 1'($urandom);
      tog       = ~tog;
      #1;
      if (stalled) begin
        chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_hold_prod"}, 32'(out_prod), 32'(held_prod));
        chk({tag, "_hold_apx"}, 32'(out_approx), 32'(held_apx));
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
        chk({tag, "_in_ready_stall"}, 32'(in_ready), 32'd0);
        held_prod = out_prod;
        held_apx  = out_approx;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk({tag, "_unexpected_out"}, 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk({tag, "_prod"}, 32'(out_prod), 32'(e[15:0]));
          chk({tag, "_apx"}, 32'(out_approx), 32'(e[16]));
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_a, in_b, in_mode));
        sent++;
        pend = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk({tag, "_delivered"}, 32'(got), 32'(n));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n_apx;

    vecs[0]  = '{8'h35, 8'h12, 1'b1, 16'h037F, 1'b1};
    vecs[1]  = '{8'h35, 8'h12, 1'b0, 16'h03BA, 1'b0};
    vecs[2]  = '{8'h0F, 8'h03, 1'b1, 16'h002D, 1'b0};
    vecs[3]  = '{8'h10, 8'h10, 1'b1, 16'h0100, 1'b1};
    vecs[4]  = '{8'hFF, 8'hFF, 1'b1, 16'hE1FF, 1'b1};
    vecs[5]  = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, 1'b0};
    vecs[6]  = '{8'h00, 8'h00, 1'b1, 16'h0000, 1'b0};
    vecs[7]  = '{8'h80, 8'h01, 1'b1, 16'h001F, 1'b1};
    vecs[8]  = '{8'h01, 8'h80, 1'b0, 16'h0080, 1'b0};
    vecs[9]  = '{8'h0A, 8'hB0, 1'b1, 16'h00FF, 1'b1};
    vecs[10] = '{8'h23, 8'h45, 1'b1, 16'h087F, 1'b1};
    vecs[11] = '{8'h0F, 8'h0F, 1'b0, 16'h00E1, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_prod", 32'(out_prod), 32'd0);
    chk("rst_out_approx", 32'(out_approx), 32'd0);
    chk("rst_cnt", 32'(approx_cnt), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    n_apx = 0;
    for (int i = 0; i < 12; i++) begin
      in_a = vecs[i].a; in_b = vecs[i].b; in_mode = vecs[i].mode;
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
        tick();
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      chk($sformatf("vec%0d_prod", i), 32'(out_prod), 32'(vecs[i].prod));
      chk($sformatf("vec%0d_apx", i), 32'(out_approx), 32'(vecs[i].apx));
      if (vecs[i].apx) n_apx++;
      tick();
    end
    chk("cnt_after_table", 32'(approx_cnt), 32'(n_apx));

    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt_clr_idle", 32'(approx_cnt), 32'd0);

    stream(10, 0, "bp10");
    stream(3000, 1, "rnd");

    // Three ops in flight and output stalled, then reset
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_a = vecs[i].a; in_b = vecs[i].b; in_mode = vecs[i].mode; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("inflight_rst_valid", 32'(out_valid), 32'd0);
    chk("inflight_rst_cnt", 32'(approx_cnt), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("inflight_rst_in_ready", 32'(in_ready), 32'd1);
    lat = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) lat++;
      tick();
    end
    chk("inflight_no_stale", 32'(lat), 32'd0);

    // Saturate the counter with approximate transfers
    in_a = 8'h35; in_b = 8'h12; in_mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (65540) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("cnt_saturated", 32'(approx_cnt), 32'hFFFF);

    // Clear coincident with an approximate transfer
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    chk("clr_xfer_valid", 32'(out_valid && out_approx), 32'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_wins_over_inc", 32'(approx_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/etm_mul_pipe.md
ETM_MUL_PIPE -- requirements
Module: etm_mul_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (even, >= 4).
REQ-002 SHALL have parameter SPLIT, default WIDTH/2, width of the low (non-multiplication) part (1 <= SPLIT < WIDTH).
REQ-003 SHALL have parameter CNT_W, default 16, width of the approximation counter.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 in_a  input  WIDTH  unsigned operand A.
REQ-009 in_b  input  WIDTH  unsigned operand B.
REQ-010 in_mode  input  1  0 = exact product, 1 = ETM approximate product; sampled with operands.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_prod  output  2*WIDTH  product.
REQ-014 out_approx  output  1  1 when out_prod was produced by the approximate path.
REQ-015 cnt_clr  input  1  synchronous clear of approx_cnt.
REQ-016 approx_cnt  output  CNT_W  number of approximate results delivered, saturating.

Function
REQ-017 Notation: a_hi = in_a[WIDTH-1:SPLIT], a_lo = in_a[SPLIT-1:0]; likewise b_hi, b_lo; L = a_lo | b_lo.
REQ-018 in_mode=0: out_prod = in_a * in_b, full 2*WIDTH bits, out_approx=0.
REQ-019 in_mode=1 and a_hi==0 and b_hi==0: out_prod = a_lo * b_lo (exact), out_approx=0.
REQ-020 in_mode=1 otherwise: out_prod = ((a_hi * b_hi) << 2*SPLIT) | NM, out_approx=1.
REQ-021 NM (2*SPLIT bits): 0 when L==0; else, with p = index of highest set bit of L, NM = (1 << (p+SPLIT+1)) - 1 (bits p+SPLIT..0 set, rest 0).
REQ-022 Pipeline SHALL be three register stages: S1 operand/mode capture and path classification, S2 high-part product and NM generation, S3 result assembly into output register.
REQ-023 Latency SHALL be 3 cycles from accepted input (in_valid & in_ready) to out_valid, absent stalls.
REQ-024 Advance enable en = !out_valid | out_ready; all stages shift only when en=1; in_ready = en.
REQ-025 Bubbles (invalid stages) SHALL propagate as invalid; throughput one result per cycle when out_ready held high.
REQ-026 out_valid=1 with out_ready=0: out_prod, out_approx, out_valid SHALL hold unchanged; no input accepted.
REQ-027 Transfer occurs on out_valid & out_ready; each accepted input yields exactly one transfer, in order.
REQ-028 approx_cnt SHALL increment by 1 on each transfer with out_approx=1, saturating at 2^CNT_W-1.
REQ-029 cnt_clr=1 SHALL set approx_cnt to 0 next cycle; clear wins over simultaneous increment.
REQ-030 No combinational path from in_a/in_b/in_mode to any output; in_ready depends combinationally only on out_ready and out_valid.

Reset
REQ-031 rst=1 SHALL clear all stage valid bits; out_valid=0, out_prod=0, out_approx=0, approx_cnt=0 on the next edge.
REQ-032 rst during in-flight operations SHALL discard them; no result for those inputs appears after reset release.
REQ-033 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-034 rst SHALL take priority over in_valid, out_ready and cnt_clr in the same cycle.

Verification (WIDTH=8, SPLIT=4, CNT_W=16)
REQ-035 a=0x35, b=0x12, mode=1 -> 3 cycles later out_prod=0x037F, out_approx=1; same with mode=0 -> 0x03BA, out_approx=0.
REQ-036 a=0x0F, b=0x03, mode=1 -> out_prod=0x002D, out_approx=0; a=0x10, b=0x10, mode=1 -> 0x0100, out_approx=1; a=0xFF, b=0xFF, mode=1 -> 0xE1FF.
REQ-037 Back-to-back 10 inputs with out_ready toggling 1/0 each cycle -> all 10 results delivered in order, held stable while out_ready=0, in_ready=0 whenever out_valid=1 and out_ready=0.
REQ-038 approx_cnt preloaded by 65535+ approximate transfers -> stays 0xFFFF; cnt_clr asserted during a transfer with out_approx=1 -> approx_cnt=0.
REQ-039 rst asserted with 3 operations in flight -> next cycle out_valid=0, approx_cnt=0; no stale results after release.
REQ-040 Random 10^5 operands/modes vs. reference model of REQ-018..021 -> zero mismatches.
